// File: rtl/cache_axi_bridge.sv
// Turns cache refill / write-back requests into AXI4 INCR bursts on a 32-bit bus.
// One read and one write may be outstanding at once; reads to a pending write's line are held off.
module cache_axi_bridge (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_strb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  r_state_t     r_state_reg, r_state_next;
  w_state_t     w_state_reg, w_state_next;

  logic [31:0]  rd_addr_reg;
  logic         rd_line_reg;
  logic [31:0]  wr_addr_reg;
  logic         wr_line_reg;
  logic [3:0]   wr_strb_reg;
  logic [127:0] wr_data_reg;
  logic [1:0]   cnt_reg;
  logic         aw_done_reg;
  logic         w_done_reg;

  logic [31:0]  wr_word [4];
  logic         rd_line, wr_line;
  logic         rd_accept, wr_accept;
  logic         hazard;
  logic         aw_hs, w_hs;
  logic         unused_addr_bits;

  // Sub-word address bits are irrelevant: transfers are always 4-byte aligned.
  assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};

  assign rd_line = (rd_type == 3'b100);
  assign wr_line = (wr_type == 3'b100);

  assign wr_rdy    = resetn & (w_state_reg == W_IDLE);
  assign wr_accept = wr_req & wr_rdy;

  // A read may not overtake a write to the same line, whether pending or accepted this cycle.
  assign hazard = ((w_state_reg != W_IDLE) && (rd_addr[31:4] == wr_addr_reg[31:4])) ||
                  (wr_accept && (wr_addr[31:4] == rd_addr[31:4]));

  assign rd_rdy    = resetn & (r_state_reg == R_IDLE) & ~hazard;
  assign rd_accept = rd_req & rd_rdy;

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_reg <= R_IDLE;
    end else begin
      r_state_reg <= r_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      rd_addr_reg <= rd_line ? {rd_addr[31:4], 4'b0000} : {rd_addr[31:2], 2'b00};
      rd_line_reg <= rd_line;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ret_valid    = 1'b0;
    ret_last     = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (rd_accept) r_state_next = R_AR;
      end
      R_AR: begin
        arvalid = resetn;
        if (arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        rready    = resetn;
        ret_valid = resetn & rvalid;
        ret_last  = resetn & rlast;
        if (rvalid && rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign araddr   = rd_addr_reg;
  assign arlen    = rd_line_reg ? 8'd3 : 8'd0;
  assign ret_data = rdata;

  // ---------------- write channel ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign wr_word[gi] = wr_data_reg[32*gi +: 32];
  end

  assign awaddr  = wr_addr_reg;
  assign awlen   = wr_line_reg ? 8'd3 : 8'd0;
  assign wdata   = wr_word[cnt_reg];
  assign wstrb   = wr_line_reg ? 4'hF : wr_strb_reg;
  assign wlast   = (cnt_reg == (wr_line_reg ? 2'd3 : 2'd0));

  assign aw_hs = resetn & (w_state_reg == W_SEND) & ~aw_done_reg & awready;
  assign w_hs  = resetn & (w_state_reg == W_SEND) & ~w_done_reg & wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_reg <= W_IDLE;
      cnt_reg     <= 2'd0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      if (wr_accept) begin
        cnt_reg     <= 2'd0;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs) begin
          cnt_reg <= cnt_reg + 2'd1;
          if (wlast) w_done_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wr_addr_reg <= wr_line ? {wr_addr[31:4], 4'b0000} : {wr_addr[31:2], 2'b00};
      wr_line_reg <= wr_line;
      wr_strb_reg <= wr_strb;
      wr_data_reg <= wr_data;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (wr_accept) w_state_next = W_SEND;
      end
      W_SEND: begin
        awvalid = resetn & ~aw_done_reg;
        wvalid  = resetn & ~w_done_reg;
        // Address and final data beat may complete in either order.
        if ((aw_done_reg || aw_hs) && (w_done_reg || (w_hs && wlast)))
          w_state_next = W_RESP;
      end
      W_RESP: begin
        bready = resetn;
        if (bvalid) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: a vector table of concurrent read/write requests
// plus hand-written sequences for delayed handshakes, same-line hazards and reset mid-burst.
module tb_cache_axi_bridge;

  logic         clk;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_strb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  int n_checks = 0;
  int n_fail   = 0;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]   rtype;
    logic [31:0]  raddr;
    logic [2:0]   wtype;
    logic [31:0]  waddr;
    logic [3:0]   wstrb_in;
    logic [127:0] wdata_in;
    logic [31:0]  exp_araddr;
    logic [7:0]   exp_arlen;
    logic [31:0]  exp_awaddr;
    logic [7:0]   exp_awlen;
    logic [3:0]   exp_wstrb;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_strb = 0; wr_data = 0;
    arready = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_rready"}, rready, 1'b0);
    check({tag, "_ret_valid"}, ret_valid, 1'b0);
    check({tag, "_awvalid"}, awvalid, 1'b0);
    check({tag, "_wvalid"}, wvalid, 1'b0);
    check({tag, "_bready"}, bready, 1'b0);
    check({tag, "_rd_rdy"}, rd_rdy, 1'b0);
    check({tag, "_wr_rdy"}, wr_rdy, 1'b0);
  endtask

  // Entered with arvalid expected high; returns after the last beat plus one idle cycle.
  task automatic drain_read(input int nbeats, input logic [31:0] base);
    int c;
    logic [31:0] d;
    check("rd_arvalid_entry", arvalid, 1'b1);
    check("rd_rready_before_ar", rready, 1'b0);
    arready = 1;
    #1;
    c = 0;
    while (!rready && c < 10) begin
      tick();
      c++;
    end
    check("rd_rready_after_ar", rready, 1'b1);
    check("rd_ar_latency", c, 1);
    arready = 0;
    for (int i = 0; i < nbeats; i++) begin
      d = base * (i + 1);
      rvalid = 1; rdata = d; rlast = (i == nbeats - 1);
      #1;
      check("rd_ret_valid", ret_valid, 1'b1);
      check("rd_ret_data", ret_data, d);
      check("rd_ret_last", ret_last, (i == nbeats - 1));
      tick();
    end
    rvalid = 0; rlast = 0; rdata = 0;
    #1;
    check("rd_rdy_after_last", rd_rdy, 1'b1);
    $display("read  done: araddr=%h arlen=%0d beats=%0d", araddr, arlen, nbeats);
  endtask

  // Entered with awvalid/wvalid expected high; returns with the write FSM idle again.
  task automatic drain_write(input logic [127:0] data, input int nbeats,
                             input logic [3:0] strb, input int bdelay);
    int beats;
    int c;
    beats = 0;
    c = 0;
    awready = 1; wready = 1;
    #1;
    while (!bready && c < 20) begin
      if (wvalid && beats < 4) begin
        check("wr_wdata", wdata, data[32*beats +: 32]);
        check("wr_wstrb", wstrb, strb);
        check("wr_wlast", wlast, (beats == nbeats - 1));
        beats++;
      end
      tick();
      c++;
    end
    awready = 0; wready = 0;
    check("wr_beats", beats, nbeats);
    check("wr_bready", bready, 1'b1);
    for (int i = 0; i < bdelay; i++) begin
      check("wr_rdy_wait_b", wr_rdy, 1'b0);
      tick();
    end
    bvalid = 1;
    #1;
    check("wr_rdy_during_b", wr_rdy, 1'b0);
    tick();
    bvalid = 0;
    #1;
    check("wr_rdy_after_b", wr_rdy, 1'b1);
    $display("write done: awaddr=%h awlen=%0d beats=%0d", awaddr, awlen, beats);
  endtask

  initial begin
    logic [127:0] wb_data;
    int beats;
    int c;
    logic [31:0] held;

    vecs[0] = '{3'b100, 32'h1C00_0024, 3'b010, 32'h8000_0006, 4'b0011,
                128'h0000_0000_0000_0000_0000_0000_CAFE_0001,
                32'h1C00_0020, 8'd3, 32'h8000_0004, 8'd0, 4'b0011};
    vecs[1] = '{3'b010, 32'h0000_1237, 3'b100, 32'h0000_500C, 4'b0001,
                128'h4444_4444_3333_3333_2222_2222_1111_1111,
                32'h0000_1234, 8'd0, 32'h0000_5000, 8'd3, 4'hF};
    vecs[2] = '{3'b000, 32'hFFFF_FFFF, 3'b111, 32'h1234_567B, 4'b1000,
                128'h0000_0000_0000_0000_0000_0000_0BAD_F00D,
                32'hFFFF_FFFC, 8'd0, 32'h1234_5678, 8'd0, 4'b1000};
    vecs[3] = '{3'b100, 32'h0000_000F, 3'b100, 32'hABCD_EF1F, 4'b0000,
                128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0,
                32'h0000_0000, 8'd3, 32'hABCD_EF10, 8'd3, 4'hF};

    // Reset: requests presented during reset must not be accepted.
    clear_inputs();
    resetn = 0;
    rd_req = 1; wr_req = 1;
    repeat (3) tick();
    check_all_quiet("reset");
    resetn = 1;
    rd_req = 0; wr_req = 0;
    #1;
    check("post_reset_rd_rdy", rd_rdy, 1'b1);
    check("post_reset_wr_rdy", wr_rdy, 1'b1);
    tick();
    check("post_reset_arvalid", arvalid, 1'b0);
    check("post_reset_awvalid", awvalid, 1'b0);

    // Table: concurrent read and write to different lines.
    for (int i = 0; i < 4; i++) begin
      rd_req = 1; rd_type = vecs[i].rtype; rd_addr = vecs[i].raddr;
      wr_req = 1; wr_type = vecs[i].wtype; wr_addr = vecs[i].waddr;
      wr_strb = vecs[i].wstrb_in; wr_data = vecs[i].wdata_in;
      #1;
      check("vec_rd_rdy", rd_rdy, 1'b1);
      check("vec_wr_rdy", wr_rdy, 1'b1);
      tick();
      rd_req = 0; wr_req = 0; wr_data = 0; wr_strb = 0;
      #1;
      check("vec_arvalid", arvalid, 1'b1);
      check("vec_araddr", araddr, vecs[i].exp_araddr);
      check("vec_arlen", arlen, vecs[i].exp_arlen);
      check("vec_awvalid", awvalid, 1'b1);
      check("vec_wvalid", wvalid, 1'b1);
      check("vec_awaddr", awaddr, vecs[i].exp_awaddr);
      check("vec_awlen", awlen, vecs[i].exp_awlen);
      drain_write(vecs[i].wdata_in, int'(vecs[i].exp_awlen) + 1, vecs[i].exp_wstrb, 0);
      drain_read(int'(vecs[i].exp_arlen) + 1, 32'h1000 * (i + 1));
      tick();
    end

    // Line read with arready held off one cycle.
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h1C00_0024;
    #1;
    check("lr_rd_rdy", rd_rdy, 1'b1);
    tick();
    rd_req = 0;
    #1;
    check("lr_araddr", araddr, 32'h1C00_0020);
    check("lr_arlen", arlen, 8'd3);
    check("lr_rd_rdy_busy", rd_rdy, 1'b0);
    tick();
    check("lr_arvalid_held", arvalid, 1'b1);
    check("lr_araddr_held", araddr, 32'h1C00_0020);
    drain_read(4, 32'h11);

    // Word write with a delayed write response.
    tick();
    wr_req = 1; wr_type = 3'b000; wr_addr = 32'h8000_0004; wr_strb = 4'b0011;
    wr_data = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
    #1;
    check("ww_wr_rdy", wr_rdy, 1'b1);
    tick();
    wr_req = 0;
    #1;
    check("ww_awaddr", awaddr, 32'h8000_0004);
    check("ww_awlen", awlen, 8'd0);
    check("ww_wr_rdy_busy", wr_rdy, 1'b0);
    drain_write(128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF, 1, 4'b0011, 2);

    // Line write-back: awready late, wready toggling.
    tick();
    wb_data = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h0000_7734; wr_strb = 4'b0001;
    wr_data = wb_data;
    tick();
    wr_req = 0; wr_data = 0;
    beats = 0;
    c = 0;
    held = 0;
    for (c = 0; c < 30; c++) begin
      awready = (c == 3);
      wready = c[0];
      #1;
      if (bready) break;
      check("wb_awvalid", awvalid, (c <= 3));
      check("wb_wvalid", wvalid, (beats < 4));
      if (wvalid && beats < 4) begin
        check("wb_wdata", wdata, wb_data[32*beats +: 32]);
        check("wb_wstrb", wstrb, 4'hF);
        if (!wready) held = wdata;
        else check("wb_wdata_stable", wdata, held);
        if (wready) begin
          check("wb_wlast", wlast, (beats == 3));
          beats++;
        end
      end
      tick();
    end
    awready = 0; wready = 0;
    check("wb_beats", beats, 4);
    check("wb_bready_cycle", c, 8);
    check("wb_awaddr", awaddr, 32'h0000_7730);
    bvalid = 1;
    tick();
    bvalid = 0;
    #1;
    check("wb_wr_rdy_after_b", wr_rdy, 1'b1);
    $display("write done: line write-back awaddr=%h beats=%0d", awaddr, beats);

    // Same-line hazard: write to line 0x100 blocks a read of 0x108 but not 0x200.
    tick();
    wr_req = 1; wr_type = 3'b000; wr_addr = 32'h0000_0100; wr_strb = 4'hF;
    wr_data = 128'h0000_0000_0000_0000_0000_0000_5555_AAAA;
    rd_req = 1; rd_type = 3'b000; rd_addr = 32'h0000_0108;
    #1;
    check("raw_same_cycle_wr_rdy", wr_rdy, 1'b1);
    check("raw_same_cycle_rd_rdy", rd_rdy, 1'b0);
    tick();
    wr_req = 0;
    #1;
    check("raw_pending_rd_rdy", rd_rdy, 1'b0);
    tick();
    check("raw_pending_rd_rdy2", rd_rdy, 1'b0);
    check("raw_no_arvalid", arvalid, 1'b0);
    rd_addr = 32'h0000_0200;
    #1;
    check("raw_other_line_rd_rdy", rd_rdy, 1'b1);
    tick();
    rd_req = 0;
    #1;
    check("raw_other_araddr", araddr, 32'h0000_0200);
    check("raw_write_still_pending", awvalid, 1'b1);
    drain_write(128'h0000_0000_0000_0000_0000_0000_5555_AAAA, 1, 4'hF, 0);
    drain_read(1, 32'h77);
    rd_req = 1; rd_type = 3'b000; rd_addr = 32'h0000_0108;
    #1;
    check("raw_after_write_rd_rdy", rd_rdy, 1'b1);
    tick();
    rd_req = 0;
    #1;
    check("raw_after_write_araddr", araddr, 32'h0000_0108);
    drain_read(1, 32'h99);

    // Reset in the middle of a line read.
    tick();
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h0000_3000;
    tick();
    rd_req = 0;
    arready = 1;
    tick();
    arready = 0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1; rdata = 32'h100 + i; rlast = 0;
      tick();
    end
    resetn = 0;
    tick();
    check_all_quiet("mid_reset");
    rvalid = 0; rdata = 0;
    resetn = 1;
    #1;
    check("mid_reset_rd_rdy_release", rd_rdy, 1'b1);
    check("mid_reset_no_reissue", arvalid, 1'b0);
    rd_req = 1; rd_type = 3'b000; rd_addr = 32'h0000_0046;
    tick();
    rd_req = 0;
    #1;
    check("mid_reset_araddr", araddr, 32'h0000_0044);
    check("mid_reset_arlen", arlen, 8'd0);
    drain_read(1, 32'h5A);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
